// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register for the 5-stage ARM core. It also resolves MEM/WB operand
// forwarding on the registered source indices.
module id_exe_stage_reg #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned REG_IDX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [WIDTH-1:0]   id_pc,
  input  logic [WIDTH-1:0]   id_val_rn,
  input  logic [WIDTH-1:0]   id_val_rm,
  input  logic [REG_IDX-1:0] id_src1,
  input  logic [REG_IDX-1:0] id_src2,
  input  logic [REG_IDX-1:0] id_dest,
  input  logic [3:0]         id_exe_cmd,
  input  logic               id_mem_r_en,
  input  logic               id_mem_w_en,
  input  logic               id_wb_en,
  input  logic               id_b,
  input  logic               id_s,
  input  logic               id_imm,
  input  logic [11:0]        id_shift_operand,
  input  logic [23:0]        id_signed_imm_24,
  input  logic [3:0]         id_status,
  input  logic               fwd_en,
  input  logic               mem_wb_en,
  input  logic [REG_IDX-1:0] mem_dest,
  input  logic [WIDTH-1:0]   mem_alu_res,
  input  logic               wb_wb_en,
  input  logic [REG_IDX-1:0] wb_dest,
  input  logic [WIDTH-1:0]   wb_value,
  output logic               exe_valid,
  output logic [WIDTH-1:0]   exe_pc,
  output logic [REG_IDX-1:0] exe_src1,
  output logic [REG_IDX-1:0] exe_src2,
  output logic [REG_IDX-1:0] exe_dest,
  output logic [3:0]         exe_exe_cmd,
  output logic               exe_mem_r_en,
  output logic               exe_mem_w_en,
  output logic               exe_wb_en,
  output logic               exe_b,
  output logic               exe_s,
  output logic               exe_imm,
  output logic [11:0]        exe_shift_operand,
  output logic [23:0]        exe_signed_imm_24,
  output logic [3:0]         exe_status,
  output logic               exe_mem_command,
  output logic [WIDTH-1:0]   exe_val_rn,
  output logic [WIDTH-1:0]   exe_val_rm,
  output logic [1:0]         exe_sel_src1,
  output logic [1:0]         exe_sel_src2
);

  localparam logic [1:0] SelReg = 2'd0;
  localparam logic [1:0] SelMem = 2'd1;
  localparam logic [1:0] SelWb  = 2'd2;
  localparam logic [REG_IDX-1:0] PcIdx = {REG_IDX{1'b1}};

  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   pc_q, pc_d, val_rn_q, val_rn_d, val_rm_q, val_rm_d;
  logic [REG_IDX-1:0] src1_q, src1_d, src2_q, src2_d, dest_q, dest_d;
  logic [3:0]         exe_cmd_q, exe_cmd_d, status_q, status_d;
  logic               mem_r_en_q, mem_r_en_d, mem_w_en_q, mem_w_en_d;
  logic               wb_en_q, wb_en_d, b_q, b_d, s_q, s_d, imm_q, imm_d;
  logic [11:0]        shift_operand_q, shift_operand_d;
  logic [23:0]        signed_imm_24_q, signed_imm_24_d;

  always_comb begin
    valid_d         = valid_q;
    pc_d            = pc_q;
    val_rn_d        = val_rn_q;
    val_rm_d        = val_rm_q;
    src1_d          = src1_q;
    src2_d          = src2_q;
    dest_d          = dest_q;
    exe_cmd_d       = exe_cmd_q;
    mem_r_en_d      = mem_r_en_q;
    mem_w_en_d      = mem_w_en_q;
    wb_en_d         = wb_en_q;
    b_d             = b_q;
    s_d             = s_q;
    imm_d           = imm_q;
    shift_operand_d = shift_operand_q;
    signed_imm_24_d = signed_imm_24_q;
    status_d        = status_q;
    if (flush) begin
      valid_d         = 1'b0;
      pc_d            = '0;
      val_rn_d        = '0;
      val_rm_d        = '0;
      src1_d          = '0;
      src2_d          = '0;
      dest_d          = '0;
      exe_cmd_d       = '0;
      mem_r_en_d      = 1'b0;
      mem_w_en_d      = 1'b0;
      wb_en_d         = 1'b0;
      b_d             = 1'b0;
      s_d             = 1'b0;
      imm_d           = 1'b0;
      shift_operand_d = '0;
      signed_imm_24_d = '0;
      status_d        = '0;
    end else if (!freeze) begin
      valid_d         = id_valid;
      pc_d            = id_pc;
      val_rn_d        = id_val_rn;
      val_rm_d        = id_val_rm;
      src1_d          = id_src1;
      src2_d          = id_src2;
      dest_d          = id_dest;
      exe_cmd_d       = id_exe_cmd;
      // Side-effecting control is gated so an invalid slot can never write or branch.
      mem_r_en_d      = id_mem_r_en & id_valid;
      mem_w_en_d      = id_mem_w_en & id_valid;
      wb_en_d         = id_wb_en & id_valid;
      b_d             = id_b & id_valid;
      s_d             = id_s & id_valid;
      imm_d           = id_imm;
      shift_operand_d = id_shift_operand;
      signed_imm_24_d = id_signed_imm_24;
      status_d        = id_status;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q         <= 1'b0;
      pc_q            <= '0;
      val_rn_q        <= '0;
      val_rm_q        <= '0;
      src1_q          <= '0;
      src2_q          <= '0;
      dest_q          <= '0;
      exe_cmd_q       <= '0;
      mem_r_en_q      <= 1'b0;
      mem_w_en_q      <= 1'b0;
      wb_en_q         <= 1'b0;
      b_q             <= 1'b0;
      s_q             <= 1'b0;
      imm_q           <= 1'b0;
      shift_operand_q <= '0;
      signed_imm_24_q <= '0;
      status_q        <= '0;
    end else begin
      valid_q         <= valid_d;
      pc_q            <= pc_d;
      val_rn_q        <= val_rn_d;
      val_rm_q        <= val_rm_d;
      src1_q          <= src1_d;
      src2_q          <= src2_d;
      dest_q          <= dest_d;
      exe_cmd_q       <= exe_cmd_d;
      mem_r_en_q      <= mem_r_en_d;
      mem_w_en_q      <= mem_w_en_d;
      wb_en_q         <= wb_en_d;
      b_q             <= b_d;
      s_q             <= s_d;
      imm_q           <= imm_d;
      shift_operand_q <= shift_operand_d;
      signed_imm_24_q <= signed_imm_24_d;
      status_q        <= status_d;
    end
  end

  // MEM is checked first: it holds the younger producer of the same register.
  always_comb begin
    exe_sel_src1 = SelReg;
    exe_val_rn   = val_rn_q;
    if (fwd_en && valid_q && (src1_q != PcIdx)) begin
      if (mem_wb_en && (mem_dest == src1_q)) begin
        exe_sel_src1 = SelMem;
        exe_val_rn   = mem_alu_res;
      end else if (wb_wb_en && (wb_dest == src1_q)) begin
        exe_sel_src1 = SelWb;
        exe_val_rn   = wb_value;
      end
    end
  end

  always_comb begin
    exe_sel_src2 = SelReg;
    exe_val_rm   = val_rm_q;
    if (fwd_en && valid_q && (src2_q != PcIdx)) begin
      if (mem_wb_en && (mem_dest == src2_q)) begin
        exe_sel_src2 = SelMem;
        exe_val_rm   = mem_alu_res;
      end else if (wb_wb_en && (wb_dest == src2_q)) begin
        exe_sel_src2 = SelWb;
        exe_val_rm   = wb_value;
      end
    end
  end

  assign exe_valid         = valid_q;
  assign exe_pc            = pc_q;
  assign exe_src1          = src1_q;
  assign exe_src2          = src2_q;
  assign exe_dest          = dest_q;
  assign exe_exe_cmd       = exe_cmd_q;
  assign exe_mem_r_en      = mem_r_en_q;
  assign exe_mem_w_en      = mem_w_en_q;
  assign exe_wb_en         = wb_en_q;
  assign exe_b             = b_q;
  assign exe_s             = s_q;
  assign exe_imm           = imm_q;
  assign exe_shift_operand = shift_operand_q;
  assign exe_signed_imm_24 = signed_imm_24_q;
  assign exe_status        = status_q;
  assign exe_mem_command   = mem_r_en_q | mem_w_en_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg: directed vectors push expected EXE-side snapshots,
// and a negedge monitor pops and compares them.
module tb_id_exe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, id_valid;
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic [3:0]  id_src1, id_src2, id_dest, id_exe_cmd, id_status;
  logic        id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s, id_imm;
  logic [11:0] id_shift_operand;
  logic [23:0] id_signed_imm_24;
  logic        fwd_en, mem_wb_en, wb_wb_en;
  logic [3:0]  mem_dest, wb_dest;
  logic [31:0] mem_alu_res, wb_value;

  logic        exe_valid, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s, exe_imm;
  logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
  logic [3:0]  exe_src1, exe_src2, exe_dest, exe_exe_cmd, exe_status;
  logic [11:0] exe_shift_operand;
  logic [23:0] exe_signed_imm_24;
  logic        exe_mem_command;
  logic [1:0]  exe_sel_src1, exe_sel_src2;

  id_exe_stage_reg #(.WIDTH(32), .REG_IDX(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
    .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest), .id_exe_cmd(id_exe_cmd),
    .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en),
    .id_b(id_b), .id_s(id_s), .id_imm(id_imm), .id_shift_operand(id_shift_operand),
    .id_signed_imm_24(id_signed_imm_24), .id_status(id_status),
    .fwd_en(fwd_en), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_alu_res(mem_alu_res),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_src1(exe_src1), .exe_src2(exe_src2),
    .exe_dest(exe_dest), .exe_exe_cmd(exe_exe_cmd), .exe_mem_r_en(exe_mem_r_en),
    .exe_mem_w_en(exe_mem_w_en), .exe_wb_en(exe_wb_en), .exe_b(exe_b), .exe_s(exe_s),
    .exe_imm(exe_imm), .exe_shift_operand(exe_shift_operand),
    .exe_signed_imm_24(exe_signed_imm_24), .exe_status(exe_status),
    .exe_mem_command(exe_mem_command), .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm),
    .exe_sel_src1(exe_sel_src1), .exe_sel_src2(exe_sel_src2)
  );

  always #5 clk = ~clk;

  // {valid, pc, val_rn, val_rm, sel1, sel2, wb_en, b, mem_command, shift_operand}
  typedef struct {
    string        name;
    logic [115:0] snap;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [115:0] pack(logic v, logic [31:0] pc, logic [31:0] rn,
                                        logic [31:0] rm, logic [1:0] s1, logic [1:0] s2,
                                        logic wb, logic b, logic mc, logic [11:0] sh);
    return {v, pc, rn, rm, s1, s2, wb, b, mc, sh};
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [115:0] act;
      e   = q.pop_front();
      act = pack(exe_valid, exe_pc, exe_val_rn, exe_val_rm, exe_sel_src1, exe_sel_src2,
                 exe_wb_en, exe_b, exe_mem_command, exe_shift_operand);
      n_vec++;
      if (act !== e.snap) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.snap);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation, then let the monitor sample it before inputs move again.
  task automatic expect_v(string name, logic v, logic [31:0] pc, logic [31:0] rn,
                          logic [31:0] rm, logic [1:0] s1, logic [1:0] s2, logic wb,
                          logic b, logic mc, logic [11:0] sh);
    exp_t e;
    e.name = name;
    e.snap = pack(v, pc, rn, rm, s1, s2, wb, b, mc, sh);
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic set_id(logic v, logic [31:0] pc, logic [31:0] rn, logic [31:0] rm,
                        logic [3:0] s1, logic [3:0] s2, logic wb, logic b, logic mr,
                        logic mw, logic [11:0] sh);
    id_valid = v; id_pc = pc; id_val_rn = rn; id_val_rm = rm;
    id_src1 = s1; id_src2 = s2; id_wb_en = wb; id_b = b;
    id_mem_r_en = mr; id_mem_w_en = mw; id_shift_operand = sh;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    set_id(1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    id_dest = 4'h0; id_exe_cmd = 4'h0; id_status = 4'h0; id_s = 1'b0; id_imm = 1'b0;
    id_signed_imm_24 = 24'h0;
    fwd_en = 1'b0; mem_wb_en = 1'b0; wb_wb_en = 1'b0; mem_dest = 4'h0; wb_dest = 4'h0;
    mem_alu_res = 32'h0; wb_value = 32'h0;
    #2;
    expect_v("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0);
    rst = 1'b0;

    set_id(1'b1, 32'h10, 32'h55, 32'h1234, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A3);
    tick();
    expect_v("load", 1, 32'h10, 32'h55, 32'h1234, 0, 0, 0, 0, 0, 12'h0A3);

    set_id(1'b1, 32'h20, 32'hA1, 32'hA2, 4'd1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 12'h111);
    tick();
    expect_v("load_a", 1, 32'h20, 32'hA1, 32'hA2, 0, 0, 1, 0, 1, 12'h111);
    freeze = 1'b1;
    set_id(1'b1, 32'h30, 32'hB1, 32'hB2, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 12'h222);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_v("freeze_hold", 1, 32'h20, 32'hA1, 32'hA2, 0, 0, 1, 0, 1, 12'h111);
    end
    freeze = 1'b0;
    tick();
    expect_v("load_b", 1, 32'h30, 32'hB1, 32'hB2, 0, 0, 0, 1, 0, 12'h222);

    set_id(1'b0, 32'h40, 32'hC1, 32'hC2, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 12'h333);
    tick();
    expect_v("invalid_ctrl", 0, 32'h40, 32'hC1, 32'hC2, 0, 0, 0, 0, 0, 12'h333);

    set_id(1'b1, 32'h50, 32'hD1, 32'hD2, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 12'h444);
    flush = 1'b1;
    tick();
    expect_v("flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0);
    flush = 1'b0;
    tick();
    expect_v("reload", 1, 32'h50, 32'hD1, 32'hD2, 0, 0, 1, 1, 0, 12'h444);
    flush = 1'b1; freeze = 1'b1;
    tick();
    expect_v("flush_freeze", 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0);
    flush = 1'b0; freeze = 1'b0;

    set_id(1'b1, 32'h60, 32'h111, 32'h222, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    tick();
    freeze = 1'b1;
    fwd_en = 1'b1; mem_wb_en = 1'b1; mem_dest = 4'd3; mem_alu_res = 32'hAAAA;
    wb_wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hBBBB;
    #1;
    expect_v("fwd_mem_wins", 1, 32'h60, 32'h111, 32'hAAAA, 0, 1, 0, 0, 0, 12'h0);
    mem_wb_en = 1'b0;
    #1;
    expect_v("fwd_wb", 1, 32'h60, 32'h111, 32'hBBBB, 0, 2, 0, 0, 0, 12'h0);
    mem_wb_en = 1'b1; wb_dest = 4'd5;
    #1;
    expect_v("fwd_split", 1, 32'h60, 32'hBBBB, 32'hAAAA, 2, 1, 0, 0, 0, 12'h0);
    fwd_en = 1'b0;
    #1;
    expect_v("fwd_off", 1, 32'h60, 32'h111, 32'h222, 0, 0, 0, 0, 0, 12'h0);
    freeze = 1'b0;

    set_id(1'b1, 32'h70, 32'h333, 32'h444, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    fwd_en = 1'b1; mem_dest = 4'd15; wb_dest = 4'd15;
    tick();
    expect_v("r15_no_fwd", 1, 32'h70, 32'h333, 32'h444, 0, 0, 0, 0, 0, 12'h0);
    set_id(1'b0, 32'h80, 32'h555, 32'h666, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    mem_dest = 4'd3; wb_dest = 4'd3;
    tick();
    expect_v("bubble_no_fwd", 0, 32'h80, 32'h555, 32'h666, 0, 0, 0, 0, 0, 12'h0);
    fwd_en = 1'b0; mem_wb_en = 1'b0; wb_wb_en = 1'b0;

    set_id(1'b1, 32'h90, 32'h777, 32'h888, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 12'h555);
    tick();
    expect_v("pre_reset", 1, 32'h90, 32'h777, 32'h888, 0, 0, 1, 0, 1, 12'h555);
    tick();
    #1 rst = 1'b1;
    #1;
    expect_v("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0);
    expect_v("reset_held", 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0);
    rst = 1'b0;
    tick();
    expect_v("post_reset", 1, 32'h90, 32'h777, 32'h888, 0, 0, 1, 0, 1, 12'h555);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
